// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave with TX/RX FIFOs.
//   spi_state_e      : frame FSM states (IDLE, SHIFT)
//   SPI_FILL_DEFAULT : default word sent when the TX FIFO is empty at a word start
//   lvl_w()          : width of a FIFO occupancy counter holding 0..depth
package spi_pkg;

  typedef enum logic {IDLE, SHIFT} spi_state_e;

  localparam int unsigned SPI_FILL_DEFAULT = 0;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Show-ahead synchronous FIFO in the sclk domain.
//   sclk, rst_n : clock, async active-low reset
//   push, din   : write request and data (ignored while full)
//   pop         : read request (ignored while empty)
//   dout        : head entry, 0 while empty
//   full, empty : occupancy status taken before this edge's push/pop
//   level       : occupancy, 0..DEPTH
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Full/empty come from the pre-edge level, so a push into an empty FIFO
  // cannot be popped on the same edge and a full FIFO drops a push even if
  // a pop happens alongside it.
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave with chip-select framing, selectable bit order, back-to-back
// multi-word frames and valid/ready TX/RX FIFOs.
//   sclk, rst_n          : SPI clock (sole clock), async active-low reset
//   cs_n, mosi, miso     : SPI pins; miso comes straight from a register
//   tx_data/valid/ready  : words to send, pushed into the TX FIFO
//   rx_data/valid/ready  : received words, show-ahead head of the RX FIFO
//   tx_level, rx_level   : FIFO occupancies
//   word_done            : pulse after each completed word
//   frame_abort          : pulse when cs_n rises mid-word
//   tx_underrun          : sticky, a word start found the TX FIFO empty
//   rx_overrun           : sticky, a completed word hit a full RX FIFO
//   status_clr           : clears both sticky flags (a same-cycle set wins)
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 4,
  parameter bit                    MSB_FIRST  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(SPI_FILL_DEFAULT)
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         cs_n,
  input  logic                         mosi,
  output logic                         miso,
  input  logic [DATA_WIDTH-1:0]        tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [DATA_WIDTH-1:0]        rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [lvl_w(FIFO_DEPTH)-1:0] tx_level,
  output logic [lvl_w(FIFO_DEPTH)-1:0] rx_level,
  output logic                         word_done,
  output logic                         frame_abort,
  output logic                         tx_underrun,
  output logic                         rx_overrun,
  input  logic                         status_clr
);

  localparam int CW = $clog2(DATA_WIDTH);

  spi_state_e            state_q, state_d;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_in, shift_out, shift_out_nx, rx_word, tx_head;
  logic                  last_bit, word_start, shift_en, abort_edge, rx_push;
  logic                  tx_full, tx_empty, rx_full, rx_empty;

  assign last_bit = bit_cnt == CW'(DATA_WIDTH - 1);
  assign rx_push  = shift_en && last_bit;

  // Word as it stands after this edge's mosi bit is taken in.
  assign rx_word      = MSB_FIRST ? {shift_in[DATA_WIDTH-2:0], mosi}
                                  : {mosi, shift_in[DATA_WIDTH-1:1]};
  assign shift_out_nx = MSB_FIRST ? {shift_out[DATA_WIDTH-2:0], 1'b0}
                                  : {1'b0, shift_out[DATA_WIDTH-1:1]};

  // shift_out is zeroed whenever the FSM sits in IDLE, so miso is a plain
  // register bit with no gating.
  assign miso = MSB_FIRST ? shift_out[DATA_WIDTH-1] : shift_out[0];

  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    shift_en   = 1'b0;
    abort_edge = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_n) begin
          state_d    = SHIFT;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_n) begin
          state_d    = IDLE;
          abort_edge = bit_cnt != '0;
        end else begin
          shift_en   = 1'b1;
          word_start = last_bit;   // reload on the last bit: no gap edge
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      word_done   <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_done   <= rx_push;
      frame_abort <= abort_edge;

      if (word_start)    shift_out <= tx_empty ? FILL_WORD : tx_head;
      else if (shift_en) shift_out <= shift_out_nx;
      else               shift_out <= '0;

      bit_cnt  <= (shift_en && !last_bit) ? bit_cnt + CW'(1) : '0;
      shift_in <= shift_en ? rx_word : '0;

      if (word_start && tx_empty) tx_underrun <= 1'b1;
      else if (status_clr)        tx_underrun <= 1'b0;

      if (rx_push && rx_full) rx_overrun <= 1'b1;
      else if (status_clr)    rx_overrun <= 1'b0;
    end
  end

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .sclk  (sclk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (word_start),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .sclk  (sclk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (rx_word),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: an MSB-first and an LSB-first instance share all
// inputs. A queue-level model of each is checked every cycle, and directed
// frames pin the model with hand-computed values.
module tb_spi_slave_fifo;

  logic       sclk = 1'b0;
  logic       rst_n, cs_n, mosi, tx_valid, rx_ready, status_clr;
  logic [7:0] tx_data;
  logic [1:0] miso, tx_ready, rx_valid, word_done, frame_abort, tx_underrun, rx_overrun;
  logic [7:0] rx_data [2];
  logic [2:0] tx_level [2];
  logic [2:0] rx_level [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 sclk = ~sclk;

  spi_slave_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso[0]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready),
    .tx_level(tx_level[0]), .rx_level(rx_level[0]), .word_done(word_done[0]),
    .frame_abort(frame_abort[0]), .tx_underrun(tx_underrun[0]),
    .rx_overrun(rx_overrun[0]), .status_clr(status_clr)
  );

  spi_slave_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso[1]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready),
    .tx_level(tx_level[1]), .rx_level(rx_level[1]), .word_done(word_done[1]),
    .frame_abort(frame_abort[1]), .tx_underrun(tx_underrun[1]),
    .rx_overrun(rx_overrun[1]), .status_clr(status_clr)
  );

  // ---------------- model: index 0 = MSB-first, 1 = LSB-first ----------------
  logic [7:0] txm [2][4];
  logic [7:0] rxm [2][4];
  int         txn [2], rxn [2], pos [2];   // pos = bit index within the current word
  bit         act [2], wd [2], fa [2], und [2], ovr [2];
  logic [7:0] outw [2], inw [2];

  task automatic model_reset(input int d);
    txn[d] = 0; rxn[d] = 0; pos[d] = 0; act[d] = 0;
    wd[d] = 0; fa[d] = 0; und[d] = 0; ovr[d] = 0;
    outw[d] = '0; inw[d] = '0;
  endtask

  task automatic model_step(input int d);
    bit         msb, load, wdone, abort, uset, oset, rpush, rfull, rpop, tpush;
    logic [7:0] word;
    msb = (d == 0);
    load = 0; wdone = 0; abort = 0; uset = 0; oset = 0; rpush = 0; word = '0;
    rfull = rxn[d] == 4;
    rpop  = rxn[d] > 0 && rx_ready;
    tpush = tx_valid && txn[d] < 4;
    if (!act[d]) begin
      if (!cs_n) begin act[d] = 1; pos[d] = 0; load = 1; end
    end else if (cs_n) begin
      act[d] = 0; abort = pos[d] != 0; pos[d] = 0; inw[d] = '0;
    end else begin
      if (msb) inw[d][7-pos[d]] = mosi;
      else     inw[d][pos[d]]   = mosi;
      if (pos[d] == 7) begin
        rpush = 1; wdone = 1; word = inw[d]; inw[d] = '0; pos[d] = 0; load = 1;
      end else begin
        pos[d]++;
      end
    end
    // TX: the pop sees only what was queued before this edge
    if (load) begin
      if (txn[d] > 0) begin
        outw[d] = txm[d][0];
        for (int i = 0; i < 3; i++) txm[d][i] = txm[d][i+1];
        txn[d]--;
      end else begin
        outw[d] = 8'h00;
        uset = 1;
      end
    end
    if (tpush) begin txm[d][txn[d]] = tx_data; txn[d]++; end
    // RX: a full FIFO before the edge drops the word even if popped now
    if (rpop) begin
      for (int i = 0; i < 3; i++) rxm[d][i] = rxm[d][i+1];
      rxn[d]--;
    end
    if (rpush) begin
      if (rfull) oset = 1;
      else begin rxm[d][rxn[d]] = word; rxn[d]++; end
    end
    wd[d] = wdone;
    fa[d] = abort;
    und[d] = uset ? 1'b1 : (status_clr ? 1'b0 : und[d]);
    ovr[d] = oset ? 1'b1 : (status_clr ? 1'b0 : ovr[d]);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) model_reset(d);
    forever begin
      @(posedge sclk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) model_reset(d);
        else        model_step(d);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    int         bi;
    logic       em;
    logic [7:0] ow;
    for (int d = 0; d < 2; d++) begin
      ow = outw[d];
      bi = (d == 0) ? 7 - pos[d] : pos[d];
      em = act[d] ? ow[bi] : 1'b0;
      chk($sformatf("miso[%0d]", d),        int'(miso[d]),        int'(em));
      chk($sformatf("tx_ready[%0d]", d),    int'(tx_ready[d]),    int'(txn[d] < 4));
      chk($sformatf("tx_level[%0d]", d),    int'(tx_level[d]),    txn[d]);
      chk($sformatf("rx_valid[%0d]", d),    int'(rx_valid[d]),    int'(rxn[d] > 0));
      chk($sformatf("rx_level[%0d]", d),    int'(rx_level[d]),    rxn[d]);
      chk($sformatf("rx_data[%0d]", d),     int'(rx_data[d]),     rxn[d] > 0 ? int'(rxm[d][0]) : 0);
      chk($sformatf("word_done[%0d]", d),   int'(word_done[d]),   int'(wd[d]));
      chk($sformatf("frame_abort[%0d]", d), int'(frame_abort[d]), int'(fa[d]));
      chk($sformatf("tx_underrun[%0d]", d), int'(tx_underrun[d]), int'(und[d]));
      chk($sformatf("rx_overrun[%0d]", d),  int'(rx_overrun[d]),  int'(ovr[d]));
    end
  endtask

  // Inputs change at negedge+1; outputs are compared on every negedge.
  task automatic tick();
    @(negedge sclk);
    cmp_all();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; cs_n = 1; mosi = 0; tx_valid = 0; tx_data = '0;
    rx_ready = 0; status_clr = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic push(input logic [7:0] v);
    tx_valid = 1; tx_data = v;
    tick();
    tx_valid = 0;
  endtask

  task automatic end_frame();
    cs_n = 1; mosi = 0;
    tick();
  endtask

  // Start edge plus nbits shifting edges. din/cap are in wire order, first
  // bit at cap[nbits-1]; cap[k] holds miso after the matching edge.
  task automatic frame(input logic [63:0] din, input int nbits, input int d,
                       output logic [63:0] cap, output int nwd);
    cap = '0; nwd = 0;
    for (int e = 0; e <= nbits; e++) begin
      cs_n = 0;
      mosi = (e == 0) ? 1'b0 : din[nbits-e];
      tick();
      if (e < nbits) cap[nbits-1-e] = miso[d];
      if (word_done[d]) nwd++;
    end
  endtask

  initial begin
    logic [63:0] cap;
    int          nwd;
    logic [7:0]  exp4 [4];

    do_reset();
    chk("reset_tx_ready", int'(tx_ready[0]), 1);
    chk("reset_rx_valid", int'(rx_valid[0]), 0);
    chk("reset_miso", int'(miso), 0);

    // Two-word MSB-first frame; a third word covers the reload on the last edge.
    push(8'hA5); push(8'h3C); push(8'h0F);
    chk("t1_tx_level", int'(tx_level[0]), 3);
    frame(64'h5AC3, 16, 0, cap, nwd);
    end_frame();
    chk("t1_miso_stream", int'(cap[15:0]), 16'hA53C);
    chk("t1_word_done", nwd, 2);
    chk("t1_rx_level", int'(rx_level[0]), 2);
    chk("t1_rx_first", int'(rx_data[0]), 8'h5A);
    rx_ready = 1; tick(); rx_ready = 0;
    chk("t1_rx_second", int'(rx_data[0]), 8'hC3);
    chk("t1_flags", int'({tx_underrun[0], rx_overrun[0], frame_abort[0]}), 0);

    // LSB-first: send 0x01, master sends 0x80 LSB first.
    do_reset();
    push(8'h01);
    frame(64'h01, 8, 1, cap, nwd);
    end_frame();
    chk("t2_miso_10000000", int'(cap[7:0]), 8'h80);
    chk("t2_rx_data", int'(rx_data[1]), 8'h80);

    // Empty TX FIFO: fill word, sticky underrun until cleared.
    do_reset();
    frame(64'h00, 8, 0, cap, nwd);
    end_frame();
    chk("t3_miso_fill", int'(cap[7:0]), 0);
    chk("t3_underrun", int'(tx_underrun[0]), 1);
    tick();
    chk("t3_underrun_held", int'(tx_underrun[0]), 1);
    status_clr = 1; tick(); status_clr = 0;
    chk("t3_underrun_clr", int'(tx_underrun[0]), 0);

    // RX overrun: five words into a 4-deep FIFO with no consumer.
    do_reset();
    frame(64'h11_22_33_44_55, 40, 0, cap, nwd);
    end_frame();
    chk("t4_word_done", nwd, 5);
    chk("t4_rx_level", int'(rx_level[0]), 4);
    chk("t4_overrun", int'(rx_overrun[0]), 1);
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    rx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_rx_%0d", i), int'(rx_data[0]), int'(exp4[i]));
      tick();
    end
    rx_ready = 0;
    chk("t4_rx_drained", int'(rx_valid[0]), 0);

    // Abort after 3 bits; the popped word is lost, next frame takes a fresh one.
    do_reset();
    push(8'hAA); push(8'h55);
    frame(64'h5, 3, 0, cap, nwd);
    end_frame();
    chk("t5_abort", int'(frame_abort[0]), 1);
    chk("t5_no_rx", int'(rx_level[0]), 0);
    chk("t5_tx_level", int'(tx_level[0]), 1);
    tick();
    chk("t5_abort_pulse", int'(frame_abort[0]), 0);
    frame(64'h00, 8, 0, cap, nwd);
    end_frame();
    chk("t5_next_word", int'(cap[7:0]), 8'h55);

    // Full TX FIFO, then asynchronous reset mid-word.
    do_reset();
    frame(64'h00, 8, 0, cap, nwd);
    end_frame();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("t6_tx_full", int'(tx_ready[0]), 0);
    chk("t6_tx_level", int'(tx_level[0]), 4);
    frame(64'h7, 3, 0, cap, nwd);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_levels", int'({tx_level[0], rx_level[0]}), 0);
    chk("t6_rst_miso", int'(miso), 0);
    chk("t6_rst_tx_ready", int'(tx_ready[0]), 1);
    chk("t6_rst_flags", int'({tx_underrun[0], rx_overrun[0]}), 0);
    tick();
    rst_n = 1; cs_n = 1;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) cs_n = ~cs_n;
      mosi       = 1'($urandom_range(0, 1));
      tx_valid   = 1'($urandom_range(0, 1));
      tx_data    = 8'($urandom);
      rx_ready   = ($urandom_range(0, 2) == 0);
      status_clr = ($urandom_range(0, 31) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
